// File: rtl/pov_pkg.sv
// rtl/pov_pkg.sv - shared mode encodings, GRB pixel layout and byte helpers for the POV mapper
package pov_pkg;

  typedef enum logic [1:0] {
    LOOP     = 2'd0,
    PINGPONG = 2'd1,
    ONESHOT  = 2'd2,
    PAUSE    = 2'd3
  } mode_e;

  typedef logic [23:0] pixel_t;

  localparam int G_HI = 23;
  localparam int G_LO = 16;
  localparam int R_HI = 15;
  localparam int R_LO = 8;
  localparam int B_HI = 7;
  localparam int B_LO = 0;

  // Each colour byte is shifted on its own so no bits leak between G, R and B.
  function automatic pixel_t scale_px(pixel_t p, logic [1:0] sh);
    pixel_t r;
    r[G_HI:G_LO] = p[G_HI:G_LO] >> sh;
    r[R_HI:R_LO] = p[R_HI:R_LO] >> sh;
    r[B_HI:B_LO] = p[B_HI:B_LO] >> sh;
    return r;
  endfunction

  function automatic logic [7:0] gamma8(logic [7:0] x);
    logic [15:0] sq;
    sq = {8'd0, x} * {8'd0, x};
    return sq[15:8];
  endfunction

  function automatic pixel_t gamma_px(pixel_t p);
    pixel_t r;
    r[G_HI:G_LO] = gamma8(p[G_HI:G_LO]);
    r[R_HI:R_LO] = gamma8(p[R_HI:R_LO]);
    r[B_HI:B_LO] = gamma8(p[B_HI:B_LO]);
    return r;
  endfunction

endpackage

// File: rtl/pov_frame_sequencer.sv
// rtl/pov_frame_sequencer.sv - frame timer and play-mode FSM producing frame_idx and frame_tick
module pov_frame_sequencer
  import pov_pkg::*;
#(
  parameter int NUM_FRAMES       = 30,
  parameter int CYCLES_PER_FRAME = 6_666_667,
  parameter int FRAME_W          = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         mode,
  output logic [FRAME_W-1:0] frame_idx,
  output logic               frame_tick
);

  localparam int TW = (CYCLES_PER_FRAME > 1) ? $clog2(CYCLES_PER_FRAME) : 1;
  localparam logic [TW-1:0]      T_LAST = TW'(CYCLES_PER_FRAME - 1);
  localparam logic [FRAME_W-1:0] F_LAST = FRAME_W'(NUM_FRAMES - 1);

  logic [TW-1:0]      timer_q;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               up_q, up_d;
  mode_e              mode_q;
  logic               tick;

  assign tick       = (timer_q == T_LAST);
  assign frame_tick = tick & ~reset;
  assign frame_idx  = frame_q;

  always_comb begin
    frame_d = frame_q;
    up_d    = up_q;
    case (mode_e'(mode))
      LOOP:    frame_d = (frame_q >= F_LAST) ? '0 : frame_q + 1'b1;
      PINGPONG: begin
        // Entering from another mode restarts upward; the endpoint clamps turn it around.
        up_d = (mode_q != PINGPONG) ? 1'b1 : up_q;
        if (frame_q >= F_LAST)   up_d = 1'b0;
        else if (frame_q == '0)  up_d = 1'b1;
        if (NUM_FRAMES > 1) frame_d = up_d ? frame_q + 1'b1 : frame_q - 1'b1;
      end
      ONESHOT: if (frame_q < F_LAST) frame_d = frame_q + 1'b1;
      default: frame_d = frame_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
      frame_q <= '0;
      up_q    <= 1'b1;
      mode_q  <= LOOP;
    end else begin
      timer_q <= tick ? '0 : timer_q + 1'b1;
      if (tick) begin
        frame_q <= frame_d;
        up_q    <= up_d;
        mode_q  <= mode_e'(mode);
      end
    end
  end

endmodule

// File: rtl/pov_pixel_mapper.sv
// rtl/pov_pixel_mapper.sv - multi-blade frame/angle texture fetch arbiter with tagged pixel return
// Optional POV_GAMMA_EN adds a squared-gamma stage (one extra cycle of latency).
module pov_pixel_mapper
  import pov_pkg::*;
#(
  parameter int NUM_CH           = 2,
  parameter int LED_COUNT        = 52,
  parameter int TEX_WIDTH        = 64,
  parameter int THETA_BITS       = 6,
  parameter int NUM_FRAMES       = 30,
  parameter int CYCLES_PER_FRAME = 6_666_667,
  parameter int ROM_LAT          = 1,
  parameter int PX_W             = 6,
  parameter int FRAME_W          = 8,
  parameter int ADDR_W           = $clog2(TEX_WIDTH * LED_COUNT * NUM_FRAMES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [THETA_BITS-1:0]  theta,
  input  logic [1:0]             mode,
  input  logic [1:0]             brightness,
  input  logic [NUM_CH-1:0]      req,
  input  logic [NUM_CH*PX_W-1:0] px_idx,
  output logic [NUM_CH-1:0]      gnt,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [23:0]            rom_data,
  output logic [NUM_CH-1:0]      pix_valid,
  output logic [23:0]            pix_data,
  output logic [FRAME_W-1:0]     frame_idx,
  output logic                   frame_tick
);

  localparam int CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WW      = ADDR_W + FRAME_W;
  localparam int SPACING = TEX_WIDTH / NUM_CH;

  pov_frame_sequencer #(
    .NUM_FRAMES      (NUM_FRAMES),
    .CYCLES_PER_FRAME(CYCLES_PER_FRAME),
    .FRAME_W         (FRAME_W)
  ) u_seq (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .frame_idx (frame_idx),
    .frame_tick(frame_tick)
  );

  logic [CW-1:0]         ptr_q, gnt_ch, idx;
  logic                  gnt_any;
  logic [PX_W-1:0]       px;
  logic [THETA_BITS-1:0] col;
  logic [ADDR_W-1:0]     rom_addr_d, rom_addr_q;

  // Scan from the highest offset down so the channel at the pointer wins last.
  always_comb begin
    gnt_any = 1'b0;
    gnt_ch  = '0;
    idx     = '0;
    gnt     = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = CW'((int'(ptr_q) + k) % NUM_CH);
      if (req[idx]) begin
        gnt_any = 1'b1;
        gnt_ch  = idx;
      end
    end
    if (gnt_any && !reset) gnt[gnt_ch] = 1'b1;
  end

  assign px         = px_idx[gnt_ch*PX_W +: PX_W];
  assign col        = theta + THETA_BITS'(int'(gnt_ch) * SPACING);
  assign rom_addr_d = ADDR_W'(WW'(frame_idx) * WW'(TEX_WIDTH * LED_COUNT)
                             + WW'(px) * WW'(TEX_WIDTH) + WW'(col));
  assign rom_addr   = rom_addr_q;

  logic          tv_q  [ROM_LAT+1];
  logic          tbl_q [ROM_LAT+1];
  logic [CW-1:0] tch_q [ROM_LAT+1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q      <= '0;
      rom_addr_q <= '0;
      for (int i = 0; i <= ROM_LAT; i++) begin
        tv_q[i]  <= 1'b0;
        tbl_q[i] <= 1'b0;
        tch_q[i] <= '0;
      end
    end else begin
      if (gnt_any) begin
        ptr_q      <= (gnt_ch == CW'(NUM_CH - 1)) ? '0 : gnt_ch + 1'b1;
        rom_addr_q <= rom_addr_d;
      end
      tv_q[0]  <= gnt_any;
      tbl_q[0] <= (int'(px) >= LED_COUNT);
      tch_q[0] <= gnt_ch;
      for (int i = 1; i <= ROM_LAT; i++) begin
        tv_q[i]  <= tv_q[i-1];
        tbl_q[i] <= tbl_q[i-1];
        tch_q[i] <= tch_q[i-1];
      end
    end
  end

  logic          fin_valid, fin_blank;
  logic [CW-1:0] fin_ch;
  pixel_t        fin_px;

`ifdef POV_GAMMA_EN
  logic          g_v_q, g_bl_q;
  logic [CW-1:0] g_ch_q;
  pixel_t        g_px_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      g_v_q  <= 1'b0;
      g_bl_q <= 1'b0;
      g_ch_q <= '0;
      g_px_q <= '0;
    end else begin
      g_v_q  <= tv_q[ROM_LAT];
      g_bl_q <= tbl_q[ROM_LAT];
      g_ch_q <= tch_q[ROM_LAT];
      g_px_q <= gamma_px(rom_data);
    end
  end

  assign fin_valid = g_v_q;
  assign fin_blank = g_bl_q;
  assign fin_ch    = g_ch_q;
  assign fin_px    = g_px_q;
`else
  assign fin_valid = tv_q[ROM_LAT];
  assign fin_blank = tbl_q[ROM_LAT];
  assign fin_ch    = tch_q[ROM_LAT];
  assign fin_px    = rom_data;
`endif

  logic [NUM_CH-1:0] pix_valid_q;
  pixel_t            pix_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_valid_q <= '0;
      pix_data_q  <= '0;
    end else begin
      pix_valid_q <= fin_valid ? (NUM_CH'(1) << fin_ch) : '0;
      if (fin_valid) pix_data_q <= fin_blank ? '0 : scale_px(fin_px, brightness);
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_data  = pix_data_q;

endmodule

// File: tb/tb_pov_pixel_mapper.sv
// tb/tb_pov_pixel_mapper.sv - directed vector bench for pov_pixel_mapper (4 frames, 4 cycles per frame)
module tb_pov_pixel_mapper;

  localparam int AW = $clog2(64 * 52 * 4);
`ifdef POV_GAMMA_EN
  localparam bit GAM = 1'b1;
`else
  localparam bit GAM = 1'b0;
`endif
  localparam int LAT = GAM ? 4 : 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    theta;
  logic [1:0]    mode, brightness, req;
  logic [11:0]   px_idx;
  logic [1:0]    gnt, pix_valid;
  logic [AW-1:0] rom_addr;
  logic [23:0]   rom_data, rom_word, pix_data;
  logic [7:0]    frame_idx;
  logic          frame_tick;

  int n_vec = 0;
  int n_bad = 0;

  pov_pixel_mapper #(
    .NUM_FRAMES      (4),
    .CYCLES_PER_FRAME(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .theta     (theta),
    .mode      (mode),
    .brightness(brightness),
    .req       (req),
    .px_idx    (px_idx),
    .gnt       (gnt),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .frame_idx (frame_idx),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom_word;

  typedef struct {
    int          ch;
    logic [5:0]  px;
    logic [5:0]  th;
    logic [1:0]  br;
    logic [23:0] word;
    logic [31:0] addr;
    logic [23:0] pix;
  } vec_t;

  vec_t vt [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int n);
    logic [1:0] oh;
    logic [1:0] pv;
    int lat;
    oh = '0;
    oh[v.ch] = 1'b1;
    rom_word = v.word;
    brightness = v.br;
    theta = v.th;
    px_idx = '0;
    px_idx[v.ch*6 +: 6] = v.px;
    req = oh;
    #1;
    check($sformatf("v%0d gnt", n), gnt, oh);
    lat = 0;
    pv = '0;
    for (int k = 1; k <= 8 && pv == 2'b00; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req = '0;
        check($sformatf("v%0d rom_addr", n), rom_addr, v.addr);
      end
      if (pix_valid != 2'b00) begin
        pv = pix_valid;
        lat = k;
      end
    end
    check($sformatf("v%0d latency", n), lat, LAT);
    check($sformatf("v%0d pix_valid", n), pv, oh);
    check($sformatf("v%0d pix_data", n), pix_data, v.pix);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic [1:0] pv_or;
    int pp_seq [8];
    pp_seq = '{0, 1, 2, 3, 2, 1, 0, 1};

    reset = 1'b1; req = '0; px_idx = '0; theta = '0; mode = 2'd0;
    brightness = '0; rom_word = '0;

    vt[0] = '{1, 6'd5,  6'd40, 2'd0, 24'h808080, 32'd6984,  GAM ? 24'h404040 : 24'h808080};
    vt[1] = '{0, 6'd5,  6'd40, 2'd2, 24'hFF8040, 32'd7016,  GAM ? 24'h3F1004 : 24'h3F2010};
    vt[2] = '{0, 6'd60, 6'd0,  2'd0, 24'h123456, 32'd10496, 24'h000000};
    vt[3] = '{1, 6'd51, 6'd63, 2'd1, 24'h0000FF, 32'd9951,  24'h00007F};
    vt[4] = '{0, 6'd0,  6'd63, 2'd3, 24'hF0F0F0, 32'd6719,  GAM ? 24'h1C1C1C : 24'h1E1E1E};
    vt[5] = '{1, 6'd52, 6'd10, 2'd0, 24'hFFFFFF, 32'd10026, 24'h000000};
    vt[6] = '{0, 6'd51, 6'd0,  2'd0, 24'hABCDEF, 32'd9920,  GAM ? 24'h72A4DF : 24'hABCDEF};

    repeat (2) @(negedge clk);
    req = 2'b11;
    #1;
    check("rst gnt", gnt, 2'b00);
    check("rst pix_valid", pix_valid, 2'b00);
    check("rst pix_data", pix_data, 24'h0);
    check("rst rom_addr", rom_addr, '0);
    check("rst frame_idx", frame_idx, 8'd0);
    check("rst frame_tick", frame_tick, 1'b0);

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rr both %0d", i), gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
      @(negedge clk);
    end
    req = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("rr ch1 only %0d", i), gnt, 2'b10);
      @(negedge clk);
    end
    req = 2'b00;
    #1;
    check("rr idle", gnt, 2'b00);
    repeat (3) @(negedge clk);
    req = 2'b11;
    #1;
    check("rr ptr held", gnt, 2'b01);
    @(negedge clk);
    req = 2'b00;

    for (int k = 0; k < 40 && frame_idx != 8'd2; k++) @(negedge clk);
    mode = 2'd3;
    repeat (10) @(negedge clk);
    check("pause frame", frame_idx, 8'd2);

    for (int i = 0; i < 7; i++) run_vec(vt[i], i);

    rom_word = 24'h5A5A5A;
    px_idx = 12'd5;
    req = 2'b01;
    #1;
    check("inflight gnt", gnt, 2'b01);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async gnt", gnt, 2'b00);
    check("async pix_valid", pix_valid, 2'b00);
    check("async pix_data", pix_data, 24'h0);
    check("async rom_addr", rom_addr, '0);
    check("async frame_idx", frame_idx, 8'd0);
    check("async frame_tick", frame_tick, 1'b0);
    @(negedge clk);
    req = 2'b00;
    mode = 2'd1;
    @(negedge clk);
    reset = 1'b0;
    pv_or = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      pv_or = pv_or | pix_valid;
    end
    check("dropped fetch", pv_or, 2'b00);

    check("pp frame 0", frame_idx, pp_seq[0]);
    for (int i = 1; i < 8; i++) begin
      cyc = 0;
      while (frame_tick !== 1'b1 && cyc < 12) begin
        @(negedge clk);
        cyc++;
      end
      if (i > 1) check($sformatf("pp tick gap %0d", i), cyc + 1, 4);
      @(negedge clk);
      check($sformatf("pp frame %0d", i), frame_idx, pp_seq[i]);
    end

    mode = 2'd2;
    repeat (24) @(negedge clk);
    check("oneshot end", frame_idx, 8'd3);
    repeat (8) @(negedge clk);
    check("oneshot hold", frame_idx, 8'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pov_pixel_mapper.md
Name: pov_pixel_mapper

Overview:
- Multi-blade successor to the single-strip frame/angle-to-texture mapper in the POV hologram top level.
- Sequences animation frames at a fixed rate with selectable play modes.
- Arbitrates pixel fetch requests from NUM_CH neopixel strip controllers onto one shared texture ROM port.
- Applies a per-blade angular offset and brightness scaling, then returns tagged GRB pixels to the requesting strip.

Parameters:
- NUM_CH, 2, number of strips/blades; blades are evenly spaced around the rotor.
- LED_COUNT, 52, LEDs per strip.
- TEX_WIDTH, 64, texture columns; must be a power of two; equals 2^THETA_BITS.
- THETA_BITS, 6, angle width.
- NUM_FRAMES, 30, animation frames stored in the ROM.
- CYCLES_PER_FRAME, 6_666_667, clk cycles per frame (15 FPS at 100 MHz).
- ROM_LAT, 1, ROM read latency in cycles from address to data.
- PX_W, 6, pixel index width per channel.
- ADDR_W, $clog2(TEX_WIDTH*LED_COUNT*NUM_FRAMES), ROM address width.
- FRAME_W, 8, frame index width.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous active-high reset.
- theta, in, THETA_BITS, current rotor angle from angle_mapper.
- mode, in, 2, play mode: 0 LOOP, 1 PINGPONG, 2 ONESHOT, 3 PAUSE.
- brightness, in, 2, right-shift applied to each colour byte.
- req, in, NUM_CH, per-channel pixel request.
- px_idx, in, NUM_CH*PX_W, packed LED index; channel c occupies bits [c*PX_W +: PX_W].
- gnt, out, NUM_CH, one-hot single-cycle grant.
- rom_addr, out, ADDR_W, registered ROM address.
- rom_data, in, 24, ROM read data in GRB order.
- pix_valid, out, NUM_CH, one-hot single-cycle pixel strobe.
- pix_data, out, 24, GRB pixel, meaningful only while pix_valid is nonzero.
- frame_idx, out, FRAME_W, current frame.
- frame_tick, out, 1, one-cycle pulse at each frame boundary.

Behaviour:
- Reset (asynchronous):
  - timer, frame_idx, PINGPONG direction (set to up) and round-robin pointer (set to 0) are cleared.
  - All pipeline valids, gnt, pix_valid, pix_data, rom_addr and frame_tick go to 0.
  - In-flight fetches are dropped; no pix_valid is issued for any fetch granted before reset.
- Frame sequencer:
  - timer counts 0..CYCLES_PER_FRAME-1.
  - frame_tick is high in the cycle the timer wraps, and frame_idx updates on that same edge.
  - LOOP: frame_idx runs 0..NUM_FRAMES-1, then back to 0.
  - PINGPONG: frame_idx counts up to NUM_FRAMES-1, then down to 0, then up again; endpoints are not repeated.
  - ONESHOT: frame_idx advances to NUM_FRAMES-1 and holds there.
  - PAUSE: frame_idx holds; the timer keeps running and frame_tick still pulses.
  - mode is sampled only at a tick.
  - Entering PINGPONG from another mode forces direction to up; if frame_idx is NUM_FRAMES-1 at that point, direction is set to down.
  - NUM_FRAMES=1: frame_idx stays at 0 in every mode.
- Arbiter:
  - Round-robin, at most one grant per cycle.
  - Search starts at the pointer; after a grant to channel c, the pointer becomes (c+1) mod NUM_CH.
  - A requester holds req high until it sees gnt; px_idx must be stable while req is high.
  - gnt is combinational from req and the pointer, and is valid in the same cycle.
  - No req: no gnt, and the pointer is unchanged.
- Address (registered on the grant edge):
  - frame_idx is sampled on the grant edge, so a frame tick coinciding with a grant uses the pre-tick frame.
  - col = (theta + c*(TEX_WIDTH/NUM_CH)) mod TEX_WIDTH, using natural THETA_BITS wrap.
  - rom_addr = frame*TEX_WIDTH*LED_COUNT + px*TEX_WIDTH + col.
  - The product is formed at ADDR_W+FRAME_W bits and then truncated to ADDR_W.
  - rom_addr holds its last value when there is no grant.
- Out-of-range index: if px_idx >= LED_COUNT, the fetch is tagged "blank", and pix_data is 0 regardless of rom_data.
- Return pipeline:
  - Channel tag and blank flag travel in a shift pipeline of depth ROM_LAT+1.
  - Output byte = ROM byte >> brightness, applied independently to G, R and B (no carry between bytes).
  - pix_data and pix_valid are registered.
  - Latency from the gnt cycle to the pix_valid cycle is ROM_LAT+2.
  - Throughput is one pixel per cycle.

Optional Feature:
- Macro: POV_GAMMA_EN.
- Defined:
  - Each byte is gamma-corrected as (x*x)>>8 before the brightness shift.
  - This adds one register stage, so latency becomes ROM_LAT+3.
- Undefined: linear bytes and latency ROM_LAT+2.

Decomposition:
- Package pov_pkg holds:
  - mode encodings: LOOP=2'd0, PINGPONG=2'd1, ONESHOT=2'd2, PAUSE=2'd3;
  - GRB byte field positions: G [23:16], R [15:8], B [7:0];
  - a pixel typedef, 24-bit.
- One sub-module, pov_frame_sequencer, contains timer, mode FSM, direction, frame_idx and frame_tick.

Test Plan:
- Address, defaults: frame 2, ch1, px 5, theta 40 -> col 8, rom_addr 6984, with pix_valid[1] 3 cycles after gnt.
- PINGPONG, NUM_FRAMES=4, CYCLES_PER_FRAME=4: frame_idx sequence across ticks is 0,1,2,3,2,1,0,1. Switching to ONESHOT then holds at 3.
- Round robin, both req held constantly: gnt sequence 01,10,01,10. Dropping req[0] gives 10 every cycle.
- brightness=2, rom_data 0xFF8040 -> pix_data 0x3F2010. With POV_GAMMA_EN, 0x808080 at brightness 0 -> 0x404040.
- px_idx=60 on ch0 -> pix_valid[0] with pix_data 0x000000.
- reset asserted one cycle after a grant -> no pix_valid; all outputs 0 asynchronously; frame_idx 0 after release.
